uart_report_sched: RTL and testbench
====================================

Name: uart_report_sched

Overview:
Scheduler that shares the single uart_tx byte channel between two report sources: a periodic temperature report built from the ds18b20_driver t_data, and on-demand key-event reports from FSM_KEY key_out. It sits between those sources and uart_tx. It frames each report as 3 bytes, arbitrates with key priority, and paces bytes by a fixed byte time, because uart_tx exposes no busy/ready.

Parameters:
PERIOD, 50_000_000, clk cycles between temperature report requests (1 s at 50 MHz)
BYTE_GAP, 52_100, clk cycles from one tx_din_vld pulse to the next; must be at least one UART frame time (10 bits at 9600 baud)
HDR_TEMP, 8'hAA, header byte of a temperature frame
HDR_KEY, 8'hBB, header byte of a key frame

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rpt_en  input  1  1 = accept new requests; 0 = no new requests latched; a frame in progress still completes
t_data  input  16  raw DS18B20 temperature word
key_evt  input  4  one-cycle key press pulses, one bit per key
tx_din  output  8  byte to uart_tx din
tx_din_vld  output  1  one-cycle strobe to uart_tx din_vld
busy  output  1  high from the first byte strobe until the end of the post-frame gap
frame_done  output  1  one-cycle pulse when the post-frame gap ends
key_ovf  output  1  one-cycle pulse when a key event merges into an already pending key request

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags, key mask, period counter and gap counter cleared. Reset mid-frame abandons the frame with no further strobes.
- Period counter:
  - counts 0..PERIOD-1 while rpt_en=1 and is held at 0 while rpt_en=0;
  - tick occurs when count == PERIOD-1 and sets temp_pend in the next cycle;
  - a tick while temp_pend is already set is absorbed (one report only).
- Key request:
  - any key_evt bit with rpt_en=1 sets key_pend and ORs key_evt into key_mask;
  - if key_pend is already set, or is being consumed in the same cycle, the event is kept (not lost);
  - if key_pend was already set before the event, key_ovf pulses.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if key_pend, select a key frame, else if temp_pend, select a temperature frame.
    - On selection, in the same cycle: clear the selected pend flag, snapshot the payload (key_mask and clear it, or {1'b0,t_data[10:4]}), then go to SEND with byte index 0.
  - SEND: tx_din_vld=1 for exactly one cycle with tx_din = the current byte.
    - Byte order: byte0 = header, byte1 = payload, byte2 = byte0 XOR byte1.
    - Key payload = {4'b0, key_mask}.
    - After each strobe, wait BYTE_GAP-1 idle cycles, then strobe the next byte.
    - After byte2's strobe, go to GAP.
  - GAP: wait BYTE_GAP cycles from byte2's strobe, then pulse frame_done and return to IDLE. busy drops in the same cycle.
- Latency: a request latched while IDLE produces the byte0 strobe 2 cycles after the tick or key_evt cycle. Strobes are spaced exactly BYTE_GAP cycles apart. A full frame lasts 3*BYTE_GAP cycles from byte0.
- Arbitration:
  - no preemption; a frame always completes;
  - the key frame wins when both requests are pending;
  - a temp request waits at most one key frame per arbitration cycle.
- tx_din holds its last value between strobes. The t_data snapshot is taken at selection, not per byte.
- rpt_en falling mid-frame: the frame completes; already-pending requests are still served.

Decomposition:
- Shared package uart_report_pkg holds:
  - state enum (IDLE, SEND, GAP);
  - FRAME_LEN=3;
  - byte-index type;
  - default HDR_TEMP/HDR_KEY constants.
- One sub-module, tick_gen: parameterised free-running counter with enable and one-cycle tick output. It is also reusable for the top-level 1 s counter.

Test Plan (PERIOD=100, BYTE_GAP=10):
1. Reset released, rpt_en=1, t_data=16'h0190 -> tick at cycle 99; strobes at cycles 101, 111, 121 with bytes AA, 19, B3; frame_done at 131.
2. key_evt=4'b0100 pulse while IDLE at cycle 20 -> strobes at 22, 32, 42 with bytes BB, 04, BF; busy high 22..51.
3. key_evt=0001 arrives during an active temp frame, then 0010 one cycle later -> key_ovf pulses once; next frame is BB, 03, B8, sent immediately after the temp frame's frame_done.
4. Tick and key_evt in the same cycle -> key frame first, temp frame starts right after; no strobe spacing under 10 cycles.
5. rst asserted between byte1 and byte2 -> no further strobes, all outputs 0; after release, the next frame starts cleanly with byte0.
6. rpt_en=0 for 300 cycles with key pulses -> no strobes, no key_ovf; re-enable -> first tick 100 cycles later.

Source files
------------

// File: rtl/uart_report_pkg.sv
// Shared types and constants for the UART report scheduler.
package uart_report_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int FRAME_LEN = 3;

    typedef logic [1:0] byte_idx_t;

    localparam logic [7:0] HDR_TEMP_DEF = 8'hAA;
    localparam logic [7:0] HDR_KEY_DEF  = 8'hBB;

    // Frame layout: header, payload, then header XOR payload as a check byte.
    function automatic logic [7:0] frame_byte(input logic [7:0] hdr,
                                              input logic [7:0] pl,
                                              input byte_idx_t  idx);
        case (idx)
            2'd0:    return hdr;
            2'd1:    return pl;
            default: return hdr ^ pl;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running 0..PERIOD-1 counter with enable; held at zero while disabled.
module tick_gen #(
    parameter int PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    always_comb begin
        last  = (cnt_q == CW'(PERIOD - 1));
        tick  = en && last;
        cnt_d = (!en || last) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_report_sched.sv
// Shares one uart_tx byte channel between periodic temperature reports and
// key-event reports; 3-byte frames, key priority, fixed byte pacing.
//
//   state | meaning
//   IDLE  | waiting for a pending request; key wins over temperature
//   SEND  | strobing frame bytes, BYTE_GAP cycles apart
//   GAP   | post-frame quiet time after the check byte
module uart_report_sched
    import uart_report_pkg::*;
#(
    parameter int         PERIOD   = 50_000_000,
    parameter int         BYTE_GAP = 52_100,
    parameter logic [7:0] HDR_TEMP = HDR_TEMP_DEF,
    parameter logic [7:0] HDR_KEY  = HDR_KEY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rpt_en,
    input  logic [15:0] t_data,
    input  logic [3:0]  key_evt,
    output logic [7:0]  tx_din,
    output logic        tx_din_vld,
    output logic        busy,
    output logic        frame_done,
    output logic        key_ovf
);

    localparam int            GW         = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(BYTE_GAP - 1);

    state_e        state_q, state_d;
    byte_idx_t     idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    hdr_q, hdr_d, pl_q, pl_d, tx_din_q, tx_din_d;
    logic          tx_vld_q, tx_vld_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic          temp_pend_q, temp_pend_d, key_pend_q, key_pend_d;
    logic [3:0]    key_mask_q, key_mask_d;
    logic [3:0]    evt;
    logic          take_key, take_temp, tick;
    logic          unused_tdata;

    assign unused_tdata = ^{t_data[15:11], t_data[3:0]};

    tick_gen #(.PERIOD(PERIOD)) u_period (
        .clk  (clk),
        .rst  (rst),
        .en   (rpt_en),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        hdr_d     = hdr_q;
        pl_d      = pl_q;
        tx_din_d  = tx_din_q;
        tx_vld_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        take_key  = 1'b0;
        take_temp = 1'b0;
        evt       = rpt_en ? key_evt : 4'b0;

        case (state_q)
            IDLE: begin
                if (key_pend_q) begin
                    take_key = 1'b1;
                    hdr_d    = HDR_KEY;
                    pl_d     = {4'b0, key_mask_q};
                end else if (temp_pend_q) begin
                    take_temp = 1'b1;
                    hdr_d     = HDR_TEMP;
                    pl_d      = {1'b0, t_data[10:4]};
                end
                if (take_key || take_temp) begin
                    state_d  = SEND;
                    idx_d    = '0;
                    gap_d    = GAP_RELOAD;
                    tx_vld_d = 1'b1;
                    tx_din_d = hdr_d;
                    busy_d   = 1'b1;
                end
            end
            SEND: begin
                if (gap_q == '0) begin
                    idx_d    = idx_q + 1'b1;
                    tx_vld_d = 1'b1;
                    tx_din_d = frame_byte(hdr_q, pl_q, idx_d);
                    gap_d    = GAP_RELOAD;
                    if (idx_d == byte_idx_t'(FRAME_LEN - 1)) state_d = GAP;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Events arriving while the key request is consumed re-arm it.
        temp_pend_d = (temp_pend_q && !take_temp) || tick;
        key_pend_d  = (key_pend_q && !take_key) || (|evt);
        key_mask_d  = (take_key ? 4'b0 : key_mask_q) | evt;
        ovf_d       = (|evt) && key_pend_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            hdr_q       <= '0;
            pl_q        <= '0;
            tx_din_q    <= '0;
            tx_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            temp_pend_q <= 1'b0;
            key_pend_q  <= 1'b0;
            key_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            hdr_q       <= hdr_d;
            pl_q        <= pl_d;
            tx_din_q    <= tx_din_d;
            tx_vld_q    <= tx_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            temp_pend_q <= temp_pend_d;
            key_pend_q  <= key_pend_d;
            key_mask_q  <= key_mask_d;
        end
    end

    assign tx_din     = tx_din_q;
    assign tx_din_vld = tx_vld_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign key_ovf    = ovf_q;

endmodule

// File: tb/tb_uart_report_sched.sv
// Scoreboard bench for uart_report_sched with PERIOD=100, BYTE_GAP=10.
module tb_uart_report_sched;

    localparam int PERIOD   = 100;
    localparam int BYTE_GAP = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rpt_en = 1'b0;
    logic [15:0] t_data = 16'h0;
    logic [3:0]  key_evt = 4'h0;
    logic [7:0]  tx_din;
    logic        tx_din_vld, busy, frame_done, key_ovf;

    uart_report_sched #(.PERIOD(PERIOD), .BYTE_GAP(BYTE_GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .rpt_en     (rpt_en),
        .t_data     (t_data),
        .key_evt    (key_evt),
        .tx_din     (tx_din),
        .tx_din_vld (tx_din_vld),
        .busy       (busy),
        .frame_done (frame_done),
        .key_ovf    (key_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] b;
    } stb_t;

    stb_t exp_q[$];
    int   fd_q[$];
    int   cyc = 0;
    int   base = 0;
    int   errors = 0;
    int   checks = 0;
    int   ovf_cnt = 0;
    int   ovf_rel = -1;
    int   last_stb = -1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (rel cycle %0d)", tag, got, want, cyc - base);
        end
    endtask

    function automatic logic [7:0] tpl(input logic [15:0] t);
        return {1'b0, t[10:4]};
    endfunction

    task automatic push_stb(input int c, input logic [7:0] b);
        stb_t e;
        e.c = c;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int c0, input logic [7:0] h, input logic [7:0] p);
        push_stb(c0, h);
        push_stb(c0 + BYTE_GAP, p);
        push_stb(c0 + 2 * BYTE_GAP, h ^ p);
        fd_q.push_back(c0 + 3 * BYTE_GAP);
    endtask

    task automatic wait_to(input int c);
        while (cyc - base < c) @(negedge clk);
    endtask

    task automatic pulse_key(input int c, input logic [3:0] k);
        wait_to(c);
        key_evt = k;
        wait_to(c + 1);
        key_evt = 4'h0;
    endtask

    task automatic do_reset(input logic en, input logic [15:0] td, input int hold);
        @(negedge clk);
        rst = 1'b1;
        rpt_en = en;
        t_data = td;
        key_evt = 4'h0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rst_outs", int'({tx_din, tx_din_vld, busy, frame_done, key_ovf}), 0);
        end
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic end_test(input string tag);
        chk({tag, "_strobes_left"}, exp_q.size(), 0);
        chk({tag, "_done_left"}, fd_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_stb = -1000;
        end else begin
            if (tx_din_vld) begin
                chk("strobe_spacing_ok", int'((cyc - last_stb) >= BYTE_GAP), 1);
                last_stb = cyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_strobe", int'(tx_din), -1);
                end else begin
                    stb_t e;
                    e = exp_q.pop_front();
                    chk("strobe_cyc", cyc - base, e.c);
                    chk("strobe_byte", int'(tx_din), int'(e.b));
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) chk("spurious_done", cyc - base, -1);
                else                  chk("done_cyc", cyc - base, fd_q.pop_front());
            end
            if (key_ovf) begin
                ovf_cnt++;
                ovf_rel = cyc - base;
            end
        end
    end

    initial begin
        int ovf0;

        // 1: periodic temperature frame
        do_reset(1'b1, 16'h0190, 3);
        push_frame(101, 8'hAA, tpl(16'h0190));
        wait_to(100); chk("t1_busy_100", busy, 0);
        wait_to(101); chk("t1_busy_101", busy, 1);
        wait_to(130); chk("t1_busy_130", busy, 1);
        wait_to(131); chk("t1_busy_131", busy, 0);
        wait_to(140);
        end_test("t1");

        // 2: key frame from IDLE, then the periodic frame
        do_reset(1'b1, 16'h0190, 3);
        push_frame(22, 8'hBB, 8'h04);
        push_frame(101, 8'hAA, tpl(16'h0190));
        pulse_key(20, 4'b0100);
        chk("t2_busy_21", busy, 0);
        wait_to(22); chk("t2_busy_22", busy, 1);
        wait_to(51); chk("t2_busy_51", busy, 1);
        wait_to(52); chk("t2_busy_52", busy, 0);
        wait_to(135);
        end_test("t2");

        // 3: key events merge during a temp frame, one overflow
        do_reset(1'b1, 16'h0190, 3);
        ovf0 = ovf_cnt;
        push_frame(101, 8'hAA, tpl(16'h0190));
        push_frame(132, 8'hBB, 8'h03);
        pulse_key(105, 4'b0001);
        pulse_key(106, 4'b0010);
        wait_to(170);
        chk("t3_ovf_cnt", ovf_cnt - ovf0, 1);
        chk("t3_ovf_cyc", ovf_rel, 107);
        end_test("t3");

        // 4: simultaneous tick and key; snapshot and rpt_en drop mid-frame
        do_reset(1'b1, 16'h0550, 3);
        push_frame(101, 8'hBB, 8'h08);
        push_frame(132, 8'hAA, tpl(16'h0550));
        pulse_key(99, 4'b1000);
        wait_to(135); t_data = 16'h0000;
        wait_to(140); rpt_en = 1'b0;
        wait_to(210);
        end_test("t4");

        // 5: reset between byte1 and byte2, then a clean frame
        do_reset(1'b1, 16'h0190, 3);
        push_stb(7, 8'hBB);
        push_stb(17, 8'h02);
        pulse_key(5, 4'b0010);
        wait_to(20);
        chk("t5_strobes_left", exp_q.size(), 0);
        do_reset(1'b1, 16'h0190, 12);
        push_frame(5, 8'hBB, 8'h01);
        pulse_key(3, 4'b0001);
        wait_to(40);
        end_test("t5");

        // 6: disabled for 300 cycles, then first tick 100 cycles after enable
        do_reset(1'b0, 16'h0190, 3);
        ovf0 = ovf_cnt;
        pulse_key(10, 4'b1111);
        pulse_key(50, 4'b0001);
        pulse_key(120, 4'b0010);
        wait_to(299); chk("t6_busy_299", busy, 0);
        wait_to(300); rpt_en = 1'b1;
        push_frame(401, 8'hAA, tpl(16'h0190));
        wait_to(440);
        chk("t6_ovf_cnt", ovf_cnt - ovf0, 0);
        end_test("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
